// File: rtl/simple_ctrl_seq.sv
// simple_ctrl_seq: multi-cycle FETCH/DECODE/LOAD_A/EXEC/WB sequencer driving datapath strobes; define SIMPLE_CTRL_ILLEGAL_TRAP_EN to trap nonzero IR[7:0]
module simple_ctrl_seq #(
  parameter int PC_W = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [15:0]     instr_in,
  input  logic            instr_valid,
  output logic            instr_ready,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     instruction_wire,
  output logic [2:0]      ALU_opcode_wire,
  output logic [1:0]      RF_addr,
  output logic            A_ce,
  output logic            ALU_ce,
  output logic            RF_we,
  output logic            halted,
  output logic            err
);
  typedef enum logic [2:0] {FETCH, DECODE, LOAD_A, EXEC, WB, HALTED} state_t;
  state_t state, state_n;
  logic accept, illegal, err_q;
  assign accept = state == FETCH && instr_valid;
`ifdef SIMPLE_CTRL_ILLEGAL_TRAP_EN
  assign illegal = |instruction_wire[7:0];
`else
  assign illegal = 1'b0;
`endif
  always_ff @(posedge clk)
    if (!rst) begin
      state            <= FETCH;
      instruction_wire <= '0;
      pc               <= RESET_PC;
      err_q            <= 1'b0;
    end else begin
      state <= state_n;
      err_q <= err_q | (state == DECODE && illegal);
      if (accept) begin
        instruction_wire <= instr_in;
        pc               <= pc + 1'b1;
      end
    end
  always_comb begin
    state_n = state;
    case (state)
      FETCH:   state_n = instr_valid ? DECODE : FETCH;
      DECODE:  state_n = (instruction_wire[8] || illegal) ? HALTED : instruction_wire[10] ? LOAD_A : EXEC;
      LOAD_A:  state_n = EXEC;
      EXEC:    state_n = instruction_wire[9] ? WB : FETCH;
      WB:      state_n = FETCH;
      default: state_n = HALTED;
    endcase
  end
  assign instr_ready     = state == FETCH;
  assign A_ce            = state == LOAD_A;
  assign ALU_ce          = state == EXEC;
  assign RF_we           = state == WB;
  assign halted          = state == HALTED;
  assign err             = err_q;
  assign ALU_opcode_wire = instruction_wire[15:13];
  assign RF_addr         = instruction_wire[12:11];
endmodule

// File: tb/tb_simple_ctrl_seq.sv
// tb_simple_ctrl_seq: directed checks of simple_ctrl_seq with PC_W=4
module tb_simple_ctrl_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  pc;
  logic [15:0] instruction_wire;
  logic [2:0]  ALU_opcode_wire;
  logic [1:0]  RF_addr;
  logic        A_ce, ALU_ce, RF_we, halted, err;
  int total = 0;
  int bad = 0;
  logic [3:0] pc_exp;
  simple_ctrl_seq #(.PC_W(4), .RESET_PC(4'd0)) dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc(pc), .instruction_wire(instruction_wire),
    .ALU_opcode_wire(ALU_opcode_wire), .RF_addr(RF_addr), .A_ce(A_ce),
    .ALU_ce(ALU_ce), .RF_we(RF_we), .halted(halted), .err(err)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_strobes(input string tag, input logic [2:0] exp);
    chk(tag, {29'd0, A_ce, ALU_ce, RF_we}, {29'd0, exp});
  endtask
  initial begin
    rst = 1'b0;
    instr_in = 16'h0;
    instr_valid = 1'b0;
    step();
    step();
    chk("rst_pc", pc, 0);
    chk_strobes("rst_strobes", 3'b000);
    chk("rst_ready", instr_ready, 1);
    chk("rst_halted", halted, 0);
    chk("rst_err", err, 0);
    chk("rst_ir", instruction_wire, 0);
    rst = 1'b1;
    step();
    chk("idle_ready", instr_ready, 1);
    chk("idle_pc", pc, 0);
    instr_in = 16'h2000;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("t2_dec_ready", instr_ready, 0);
    chk("t2_dec_pc", pc, 1);
    chk("t2_dec_ir", instruction_wire, 16'h2000);
    chk("t2_dec_op", ALU_opcode_wire, 3'b001);
    chk_strobes("t2_dec_strobes", 3'b000);
    step();
    chk_strobes("t2_exec_strobes", 3'b010);
    step();
    chk_strobes("t2_fetch_strobes", 3'b000);
    chk("t2_fetch_ready", instr_ready, 1);
    chk("t2_fetch_pc", pc, 1);
    instr_in = 16'hDE00;
    instr_valid = 1'b1;
    step();
    instr_in = 16'h4000;
    chk("t3_dec_rfaddr", RF_addr, 2'b11);
    chk("t3_dec_op", ALU_opcode_wire, 3'b110);
    chk("t3_dec_pc", pc, 2);
    chk_strobes("t3_dec_strobes", 3'b000);
    step();
    chk_strobes("t3_loada_strobes", 3'b100);
    chk("t3_loada_ready", instr_ready, 0);
    chk("t3_loada_ir", instruction_wire, 16'hDE00);
    step();
    chk_strobes("t3_exec_strobes", 3'b010);
    step();
    chk_strobes("t3_wb_strobes", 3'b001);
    chk("t3_wb_rfaddr", RF_addr, 2'b11);
    chk("t3_wb_pc", pc, 2);
    step();
    chk("t3_fetch_ready", instr_ready, 1);
    chk_strobes("t3_fetch_strobes", 3'b000);
    step();
    instr_valid = 1'b0;
    chk("t3_next_ir", instruction_wire, 16'h4000);
    chk("t3_next_pc", pc, 3);
    step();
    chk_strobes("t3_next_exec", 3'b010);
    step();
    chk("t3_next_ready", instr_ready, 1);
    pc_exp = 4'd3;
    for (int i = 0; i < 16; i++) begin
      instr_in = 16'h0000;
      instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      pc_exp = pc_exp + 4'd1;
      chk($sformatf("t4_pc_%0d", i), pc, pc_exp);
      step();
      chk_strobes($sformatf("t4_exec_%0d", i), 3'b010);
      step();
    end
    chk("t4_pc_final", pc, 3);
    instr_in = 16'h2000;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    chk_strobes("t5_pre_exec", 3'b010);
    rst = 1'b0;
    step();
    chk_strobes("t5_rst_strobes", 3'b000);
    chk("t5_rst_ready", instr_ready, 1);
    chk("t5_rst_pc", pc, 0);
    chk("t5_rst_ir", instruction_wire, 0);
    rst = 1'b1;
    instr_in = 16'h0700;
    instr_valid = 1'b1;
    step();
    chk("t5_dec_pc", pc, 1);
    chk("t5_dec_halted", halted, 0);
    step();
    chk("t5_halted", halted, 1);
    chk("t5_halt_ready", instr_ready, 0);
    chk_strobes("t5_halt_strobes", 3'b000);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t5_stay_ready_%0d", i), instr_ready, 0);
      chk($sformatf("t5_stay_halted_%0d", i), halted, 1);
      chk_strobes($sformatf("t5_stay_strobes_%0d", i), 3'b000);
      chk($sformatf("t5_stay_pc_%0d", i), pc, 1);
      chk($sformatf("t5_stay_ir_%0d", i), instruction_wire, 16'h0700);
    end
    rst = 1'b0;
    instr_valid = 1'b0;
    step();
    chk("t6_rst_halted", halted, 0);
    rst = 1'b1;
    instr_in = 16'h2001;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("t6_dec_ir", instruction_wire, 16'h2001);
    step();
`ifdef SIMPLE_CTRL_ILLEGAL_TRAP_EN
    chk("t6_err", err, 1);
    chk("t6_halted", halted, 1);
    chk_strobes("t6_strobes", 3'b000);
    step();
    chk("t6_err_sticky", err, 1);
    chk("t6_halted_sticky", halted, 1);
    chk_strobes("t6_strobes_after", 3'b000);
`else
    chk("t6_err", err, 0);
    chk("t6_halted", halted, 0);
    chk_strobes("t6_strobes", 3'b010);
    step();
    chk("t6_err_after", err, 0);
    chk("t6_ready_after", instr_ready, 1);
    chk_strobes("t6_strobes_after", 3'b000);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
